// File: rtl/instruction_ram_loader_pkg.sv
// Shared types and constants for the instruction RAM loader and its byte packer.
// Imported by every file of the loader.
package instruction_ram_loader_pkg;

    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2
    } state_t;

    // addi x0,x0,0
    localparam instr_t NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles little-endian bytes into 32-bit words.
// word_done strobes in the same cycle that byte 3 is accepted.
module byte_to_word_packer
    import instruction_ram_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       accept,
    input  logic [7:0] byte_data,
    output logic [1:0] bidx,
    output instr_t     word,
    output logic       word_done
);

    logic [23:0] asm_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bidx  <= 2'd0;
            asm_q <= 24'd0;
        end else if (accept) begin
            bidx <= bidx + 2'd1;
            case (bidx)
                2'd0:    asm_q[7:0]   <= byte_data;
                2'd1:    asm_q[15:8]  <= byte_data;
                2'd2:    asm_q[23:16] <= byte_data;
                default: asm_q        <= 24'd0;
            endcase
        end
    end

    // Byte 3 is taken straight from the input so the word is written without a bubble.
    assign word      = {byte_data, asm_q};
    assign word_done = accept && (bidx == 2'd3);

endmodule

// File: rtl/instruction_ram_loader.sv
// Loads a program byte stream into a flip-flop instruction RAM while holding the CPU in reset.
// load_end pads the rest of the RAM with NOPs; a trailing partial word is dropped and flagged.
module instruction_ram_loader
    import instruction_ram_loader_pkg::*;
#(
    parameter int     SIZE     = 16,
    parameter instr_t NOP_WORD = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_end,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] a,
    output logic [31:0] rd,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err,
    output state_t      dbg_state
);

    localparam int AW = $clog2(SIZE);
    localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
    // byte_ready depends only on state and load_end, never on byte_valid.

    state_t          state_q, state_d;
    logic [AW-1:0]   waddr_q;
    instr_t          mem [SIZE];

    logic            accept, start, clear_pack, word_done, mem_we, finishing;
    logic [1:0]      bidx;
    instr_t          pack_word, wdata;
    logic            unused_a_bits;

    assign byte_ready = (state_q == LOAD) && !load_end;
    assign accept     = byte_valid && byte_ready;
    assign start      = (state_q == IDLE) && load_start;
    // A pending partial word is thrown away when load_end arrives.
    assign clear_pack = start || ((state_q == LOAD) && load_end);

    byte_to_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_pack),
        .accept    (accept),
        .byte_data (byte_data),
        .bidx      (bidx),
        .word      (pack_word),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load_start) state_d = LOAD;
            LOAD: begin
                if (load_end)                            state_d = FILL;
                else if (word_done && (waddr_q == LAST)) state_d = IDLE;
            end
            FILL: if (waddr_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        wdata  = pack_word;
        case (state_q)
            LOAD: mem_we = word_done;
            FILL: begin
                mem_we = 1'b1;
                wdata  = NOP_WORD;
            end
            default: mem_we = 1'b0;
        endcase
    end

    assign finishing = (state_q != IDLE) && (state_d == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q   <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_rst   <= 1'b1;
        end else begin
            load_done <= finishing;
            cpu_rst   <= (state_d != IDLE);
            if (start)       waddr_q <= '0;
            else if (mem_we) waddr_q <= waddr_q + AW'(1);
            if (start)
                load_err <= 1'b0;
            else if ((state_q == LOAD) && load_end && (bidx != 2'd0))
                load_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) mem[i] <= NOP_WORD;
        end else if (mem_we) begin
            mem[waddr_q] <= wdata;
        end
    end

    assign rd            = mem[a[AW-1:0]];
    assign dbg_state     = state_q;
    assign unused_a_bits = ^a[31:AW];

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Directed bench for instruction_ram_loader: expected RAM image queued as bytes are driven,
// popped and compared on CPU-side readback.
module tb_instruction_ram_loader;
    import instruction_ram_loader_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, load_start, load_end, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, cpu_rst, load_done, load_err;
    logic [31:0] a, rd;
    state_t      dbg_state;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          words_sent = 0;
    logic [31:0] exp_q[$];

    instruction_ram_loader #(.SIZE(16), .NOP_WORD(32'h00000013)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_end   (load_end),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .a          (a),
        .rd         (rd),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (load_done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back(w);
        words_sent++;
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        words_sent = 0;
    endtask

    task automatic end_load();
        load_end = 1'b1;
        step();
        load_end = 1'b0;
        for (int i = words_sent; i < 16; i++) exp_q.push_back(NOP);
    endtask

    task automatic wait_done(output int fills);
        int n;
        fills = 0;
        n = 0;
        while (load_done !== 1'b1 && n < 64) begin
            if (dbg_state == FILL) fills++;
            step();
            n++;
        end
        if (n >= 64) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic verify_mem(input string tag);
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) begin
            a = ($urandom() & 32'hFFFF_FFF0) | 32'(i);
            #1;
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 32'd0, 32'd1);
            end else begin
                exp = exp_q.pop_front();
                check($sformatf("%s_mem%0d", tag, i), rd, exp);
            end
        end
    endtask

    logic [31:0] fib [12] = '{32'h12300293, 32'h12345337, 32'h00000093, 32'h00100113,
                              32'h002081b3, 32'h00010093, 32'h00018113, 32'hfff28293,
                              32'h00502023, 32'h00402223, 32'hfe029ae3, 32'hfe000ae3};

    initial begin
        int fills, dc0;
        logic bad;
        rst = 1'b1; load_start = 1'b0; load_end = 1'b0;
        byte_valid = 1'b0; byte_data = 8'h00; a = 32'd0;

        // reset state
        @(negedge clk);
        step(); step();
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_cpu_rst", 32'(cpu_rst), 32'd0);
        for (int i = 0; i < 16; i++) exp_q.push_back(NOP);
        verify_mem("reset");

        // Fibonacci program, padded by load_end at a word boundary
        start_load();
        check("fib_state_load", 32'(dbg_state), 32'(LOAD));
        check("fib_cpu_rst", 32'(cpu_rst), 32'd1);
        for (int w = 0; w < 12; w++) send_word(fib[w]);
        dc0 = done_cnt;
        end_load();
        wait_done(fills);
        check("fib_fill_cycles", 32'(fills), 32'd4);
        check("fib_cpu_rst_at_done", 32'(cpu_rst), 32'd0);
        check("fib_load_err", 32'(load_err), 32'd0);
        step(); step();
        check("fib_done_pulses", 32'(done_cnt - dc0), 32'd1);
        verify_mem("fib");

        // 64 bytes with byte_valid toggling
        start_load();
        for (int w = 0; w < 16; w++)
            exp_q.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        bad = 1'b0;
        dc0 = done_cnt;
        for (int b = 0; b < 64; b++) begin
            if (cpu_rst !== 1'b1) bad = 1'b1;
            send_byte(8'(b));
            if (b != 63) begin
                if (cpu_rst !== 1'b1) bad = 1'b1;
                step();
            end
        end
        check("stream_done_after_last", 32'(load_done), 32'd1);
        check("stream_cpu_rst_released", 32'(cpu_rst), 32'd0);
        check("stream_cpu_rst_held", 32'(bad), 32'd0);
        step(); step();
        check("stream_done_pulses", 32'(done_cnt - dc0), 32'd1);
        verify_mem("stream");

        // partial word discarded
        start_load();
        send_word(32'hDDCCBBAA);
        send_byte(8'h11);
        send_byte(8'h22);
        end_load();
        check("partial_load_err_set", 32'(load_err), 32'd1);
        wait_done(fills);
        check("partial_fill_cycles", 32'(fills), 32'd15);
        step(); step();
        check("partial_load_err_sticky", 32'(load_err), 32'd1);
        verify_mem("partial");

        // load_start ignored mid-load; load_end with a byte at a word boundary
        start_load();
        check("restart_load_err_clear", 32'(load_err), 32'd0);
        send_word(32'h01234567);
        send_byte(8'h0F);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("ignored_start_state", 32'(dbg_state), 32'(LOAD));
        send_byte(8'h1E); send_byte(8'h2D); send_byte(8'h3C);
        exp_q.push_back(32'h3C2D1E0F);
        words_sent++;
        send_word(32'hCAFEF00D);
        load_end   = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        #1;
        check("end_byte_ready_low", 32'(byte_ready), 32'd0);
        step();
        load_end   = 1'b0;
        byte_valid = 1'b0;
        for (int i = words_sent; i < 16; i++) exp_q.push_back(NOP);
        check("end_state_fill", 32'(dbg_state), 32'(FILL));
        check("end_load_err", 32'(load_err), 32'd0);
        wait_done(fills);
        check("end_fill_cycles", 32'(fills), 32'd13);
        verify_mem("boundary");

        // reset in the middle of a load
        start_load();
        for (int b = 0; b < 12; b++) send_byte(8'($urandom_range(0, 255)));
        dc0 = done_cnt;
        rst = 1'b1;
        step(); step();
        check("abort_cpu_rst_in_rst", 32'(cpu_rst), 32'd1);
        rst = 1'b0;
        step();
        check("abort_state_idle", 32'(dbg_state), 32'(IDLE));
        step(); step(); step();
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        for (int i = 0; i < 16; i++) exp_q.push_back(NOP);
        verify_mem("abort");

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
